// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer handshake, the shared FIFO write port and the
// arbiter status outputs into one interface.
//
// Signals:
//   req_valid    [NREQ]        per-producer data-valid
//   req_data     [NREQ*WIDTH]  packed producer data, port i at [i*WIDTH +: WIDTH]
//   req_ready    [NREQ]        per-producer accept strobe (from arbiter)
//   fifo_full                  full flag from the shared FIFO
//   fifo_wr_en                 shared FIFO write enable (from arbiter)
//   fifo_data_in [WIDTH]       shared FIFO write data (from arbiter)
//   grant        [NREQ]        registered one-hot owner (from arbiter)
//   busy                       registered, high while a burst is owned
//
// Modports:
//   master - environment side: producers plus FIFO full flag
//   slave  - arbiter side
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data_in;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Arbitrates NREQ producers onto one shared FIFO write port. An owner is
// chosen in IDLE (one arbitration cycle), then holds the port for up to
// MAX_BURST transfers. The burst ends early when the owner drops req_valid;
// fifo_full stalls the burst without ending it.
//
// Build option:
//   FIFO_WR_ARBITER_FIXED_PRIO_EN - when defined, IDLE selection is fixed
//   priority (lowest index wins); otherwise round-robin starting after the
//   previous winner.
//
// Ports:
//   clk   - clock, rising edge
//   rstn  - synchronous active-low reset
//   bus   - fifo_wr_arbiter_if.slave (handshake, FIFO port, grant, busy)
//
// req_ready, fifo_wr_en and fifo_data_in are combinational; grant and busy
// are registered.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rstn,
  fifo_wr_arbiter_if.slave    bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_r;
  logic [NREQ-1:0]     grant_r;
  logic                busy_r;
  logic [CW-1:0]       cnt_r;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
  logic [IDXW-1:0]     last_r;
`endif

  logic                any_valid_s;
  logic                owner_valid_s;
  logic                active_s;
  logic                xfer_s;
  logic [IDXW-1:0]     win_s;
  logic [WIDTH-1:0]    data_s;

  // One-hot decode of a port index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign any_valid_s   = |bus.req_valid;
  assign owner_valid_s = |(bus.req_valid & grant_r);
  // Gating with rstn keeps the FIFO port quiet for the whole reset cycle,
  // before the registered state has been cleared.
  assign active_s      = (state_r == BURST) && rstn;
  assign xfer_s        = active_s && owner_valid_s && !bus.fifo_full;

  assign bus.fifo_wr_en   = xfer_s;
  assign bus.req_ready    = (active_s && !bus.fifo_full) ? grant_r : '0;
  assign bus.fifo_data_in = data_s;
  assign bus.grant        = grant_r;
  assign bus.busy         = busy_r;

`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
  // Winner select: scan from the top down so the lowest set index is the
  // last assignment and therefore wins.
  always_comb begin
    win_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      win_s = bus.req_valid[k] ? IDXW'(k) : win_s;
    end
  end
`else
  // Winner select: candidates are last+1 .. last+NREQ (mod NREQ); scanning
  // from the farthest candidate back makes the nearest set one win.
  always_comb begin : rr_sel
    logic [IDXW:0]   sum_v;
    logic [IDXW-1:0] idx_v;
    win_s = '0;
    sum_v = '0;
    idx_v = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum_v = {1'b0, last_r} + (IDXW+1)'(k);
      sum_v = (sum_v >= (IDXW+1)'(NREQ)) ? (sum_v - (IDXW+1)'(NREQ)) : sum_v;
      idx_v = sum_v[IDXW-1:0];
      win_s = bus.req_valid[idx_v] ? idx_v : win_s;
    end
  end
`endif

  // Write data mux: owner's word while in BURST, zero in IDLE.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      data_s = ((state_r == BURST) && grant_r[i]) ? bus.req_data[i*WIDTH +: WIDTH] : data_s;
    end
  end

  // Arbitration / burst FSM with registered grant and busy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
      grant_r <= '0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
      last_r  <= IDXW'(NREQ - 1);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            state_r <= BURST;
            grant_r <= onehot(win_s);
            busy_r  <= 1'b1;
            cnt_r   <= '0;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
            last_r  <= win_s;
`endif
          end else begin
            state_r <= IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end
        end
        BURST: begin
          if (!owner_valid_s) begin
            // Owner went away: abandon the burst.
            state_r <= IDLE;
            grant_r <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else if (xfer_s) begin
            if (cnt_r == CW'(MAX_BURST - 1)) begin
              state_r <= IDLE;
              grant_r <= '0;
              busy_r  <= 1'b0;
              cnt_r   <= '0;
            end else begin
              cnt_r   <= cnt_r + CW'(1);
            end
          end else begin
            // Stalled on fifo_full: hold everything.
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Scoreboard bench: the driver applies inputs each negedge, runs a
// transaction-level reference model and queues the expected per-cycle status
// and expected FIFO writes; an independent monitor compares DUT outputs.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rstn;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             wr;
    logic [WIDTH-1:0] data;
    logic [NREQ-1:0]  ready;
    logic [NREQ-1:0]  grant;
    logic             busy;
  } status_t;

  status_t          stat_q[$];
  logic [WIDTH-1:0] wr_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model: who owns the FIFO (-1 = nobody), transfers done in the
  // current burst, previous winner, and per-producer stream sequence.
  int         m_owner = -1;
  int         m_cnt   = 0;
  int         m_last  = NREQ - 1;
  logic [7:0] seq[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
    return 0;
  endfunction

  // One clock of stimulus plus the model's prediction for that clock.
  task automatic cycle(input logic r, input logic [NREQ-1:0] v, input logic f);
    status_t               e;
    logic [NREQ*WIDTH-1:0] d;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i * 16) + seq[i];
    rstn          = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = f;
    e = '0;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.busy           = 1'b1;
      e.data           = d[m_owner*WIDTH +: WIDTH];
    end
    if (!r) begin
      m_owner = -1; m_cnt = 0; m_last = NREQ - 1;
    end else if (m_owner < 0) begin
      if (v != '0) begin
        m_owner = pick(v); m_last = m_owner; m_cnt = 0;
      end
    end else begin
      if (!f) e.ready[m_owner] = 1'b1;
      if (!v[m_owner]) begin
        m_owner = -1; m_cnt = 0;
      end else if (!f) begin
        e.wr = 1'b1;
        wr_q.push_back(e.data);
        seq[m_owner]++;
        m_cnt++;
        if (m_cnt == MAX_BURST) begin m_owner = -1; m_cnt = 0; end
      end
    end
    stat_q.push_back(e);
  endtask

  task automatic cycles(input int n, input logic r, input logic [NREQ-1:0] v, input logic f);
    for (int i = 0; i < n; i++) cycle(r, v, f);
  endtask

  // Monitor: compare status every cycle, pop the write queue on each write.
  initial begin
    status_t          e;
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        chk("wr_en", 32'(bus.fifo_wr_en),   32'(e.wr));
        chk("ready", 32'(bus.req_ready),    32'(e.ready));
        chk("grant", 32'(bus.grant),        32'(e.grant));
        chk("busy",  32'(bus.busy),         32'(e.busy));
        chk("data",  32'(bus.fifo_data_in), 32'(e.data));
      end
      if (bus.fifo_wr_en === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 32'(bus.fifo_data_in), 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          chk("wr_data", 32'(bus.fifo_data_in), 32'(w));
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] rv;
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) seq[i] = 8'd0;

    cycles(3, 1'b0, 4'b0000, 1'b0);
    // Single producer stream A0..A5: arb, 4 writes, gap, 2 writes.
    cycles(8, 1'b1, 4'b0001, 1'b0);
    cycles(2, 1'b1, 4'b0000, 1'b0);
    // All producers valid from reset: rotating grants.
    cycles(1, 1'b0, 4'b0000, 1'b0);
    cycles(26, 1'b1, 4'b1111, 1'b0);
    cycles(2, 1'b1, 4'b0000, 1'b0);
    // Port 2 stalled by fifo_full for 3 cycles after its 2nd transfer.
    cycles(1, 1'b0, 4'b0000, 1'b0);
    cycles(2, 1'b1, 4'b0100, 1'b0);
    cycles(1, 1'b1, 4'b0100, 1'b0);
    cycles(3, 1'b1, 4'b0100, 1'b1);
    cycles(2, 1'b1, 4'b0100, 1'b0);
    cycles(2, 1'b1, 4'b0000, 1'b0);
    // Port 1 drops after one transfer, port 3 takes over.
    cycles(1, 1'b0, 4'b0000, 1'b0);
    cycles(2, 1'b1, 4'b0010, 1'b0);
    cycles(5, 1'b1, 4'b1000, 1'b0);
    cycles(2, 1'b1, 4'b0000, 1'b0);
    // Reset mid-burst after 2 transfers, then all valid.
    cycles(1, 1'b0, 4'b0000, 1'b0);
    cycles(3, 1'b1, 4'b1111, 1'b0);
    cycles(1, 1'b0, 4'b1111, 1'b0);
    cycles(4, 1'b1, 4'b1111, 1'b0);
    // Randomized traffic with backpressure and occasional reset.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) rv[i] = ($urandom_range(0, 9) < 8);
      cycle(($urandom_range(0, 63) != 0), rv, ($urandom_range(0, 3) == 0));
    end
    cycles(3, 1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    #4;
    chk("wr_q_drained",   32'(wr_q.size()),   32'd0);
    chk("stat_q_drained", 32'(stat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of producer ports (2..8).
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 Parameter MAX_BURST, default 4, maximum transfers per grant (1..16).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NREQ  per-producer data-valid.
REQ-007 req_data  input  NREQ*WIDTH  packed producer data; port i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-producer accept strobe, combinational.
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 fifo_wr_en  output  1  shared FIFO write enable, combinational.
REQ-011 fifo_data_in  output  WIDTH  shared FIFO write data, combinational.
REQ-012 grant  output  NREQ  registered one-hot owner; all-zero when idle.
REQ-013 busy  output  1  registered; 1 while in BURST state.

Function
REQ-014 Two states: IDLE and BURST; reset enters IDLE.
REQ-015 IDLE, no req_valid bit set: remain IDLE; grant=0.
REQ-016 IDLE, any req_valid set: select winner by round-robin, searching upward from (last+1) mod NREQ; next edge: grant=onehot(winner), last=winner, burst count=0, state=BURST.
REQ-017 Arbitration costs exactly one IDLE cycle; first write occurs no earlier than the cycle after req_valid is first seen in IDLE.
REQ-018 BURST, owner g: xfer = req_valid[g] & !fifo_full; fifo_wr_en=xfer; req_ready[g]=!fifo_full; fifo_data_in=req_data[g]; all other req_ready bits 0.
REQ-019 In IDLE, fifo_wr_en=0 and req_ready=0 for all ports.
REQ-020 Each xfer increments burst count; the edge completing the MAX_BURST-th xfer returns state to IDLE and clears grant.
REQ-021 BURST with req_valid[g]=0: no write that cycle; next edge returns to IDLE, grant cleared (burst abandoned early).
REQ-022 BURST with req_valid[g]=1 and fifo_full=1: stall, no write, count unchanged, grant held indefinitely.
REQ-023 fifo_full and req_valid[g] changing same cycle: only the combination in REQ-018 decides xfer; early-end (REQ-021) takes effect only when req_valid[g]=0.
REQ-024 Burst counter width $clog2(MAX_BURST+1); it never wraps.
REQ-025 fifo_data_in when fifo_wr_en=0 is don't-care for function but shall equal req_data[g] in BURST and 0 in IDLE.

Reset
REQ-026 rstn=0 at an edge: state=IDLE, grant=0, busy=0, burst count=0, last=NREQ-1 (port 0 wins first).
REQ-027 While rstn=0, fifo_wr_en=0 and req_ready=0 regardless of inputs.
REQ-028 Reset asserted mid-burst aborts the burst with no further write; no partial state survives.

Configuration
REQ-029 Macro FIFO_WR_ARBITER_FIXED_PRIO_EN: when defined, IDLE selection is fixed priority, lowest-index set req_valid wins, last pointer unused.
REQ-030 Without FIFO_WR_ARBITER_FIXED_PRIO_EN, round-robin per REQ-016 is used; all other behaviour identical in both builds.

Verification
REQ-031 Reset, then req_valid=4'b0001, fifo_full=0, req_data[0] stream A0..A5 -> grant=0001 one cycle later; writes A0..A3 on 4 consecutive cycles; one IDLE cycle; then A4,A5 written.
REQ-032 req_valid=4'b1111 held, fifo_full=0 -> grants 0001,0010,0100,1000,0001 in order, 4 writes each, one IDLE cycle between bursts; fixed-prio build -> grant always 0001.
REQ-033 Owner port 2 in BURST, fifo_full=1 for 3 cycles after 2nd xfer -> fifo_wr_en=0 for those 3 cycles, grant stays 0100, remaining 2 writes follow when fifo_full=0.
REQ-034 Owner port 1 drops req_valid after 1 xfer, port 3 valid -> port 1 ends burst next edge with count 1; port 3 granted after one IDLE cycle.
REQ-035 rstn=0 during BURST after 2 xfers -> next cycle grant=0, busy=0, no write; after release, req_valid=1111 -> port 0 granted first.
